// File: rtl/dag_result_collector_pkg.sv
// -----------------------------------------------------------------------------
// dag_result_collector_pkg
//
// Shared definitions for the DAG micro-benchmark datapath. The DAG core, the
// result collector and the benches take their default widths and latency from
// here, so they all agree on the operand-to-result latency.
//
// Contents:
//   DAG_BITS     - width of the DAG core out0 bus
//   DAG_RES_W    - captured result width, {out1, out0}
//   DAG_LATENCY  - clock edges from operand launch to result visibility
//   DAG_DEPTH    - default result FIFO depth
//   DAG_CNT_W    - default width of the saturating drop counter
//   fifo_op_e    - encoding of the per-cycle FIFO operation
//   fifo_op()    - packs qualified push/pop strobes into a fifo_op_e
// -----------------------------------------------------------------------------
package dag_result_collector_pkg;

  localparam int DAG_BITS    = 2;
  localparam int DAG_RES_W   = DAG_BITS + 1;
  localparam int DAG_LATENCY = 3;
  localparam int DAG_DEPTH   = 4;
  localparam int DAG_CNT_W   = 8;

  // Bit 1 = pop, bit 0 = push, so the enum value is simply {pop, push}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic do_push, input logic do_pop);
    fifo_op_e op;
    case ({do_pop, do_push})
      2'b01:   op = FIFO_PUSH;
      2'b10:   op = FIFO_POP;
      2'b11:   op = FIFO_BOTH;
      default: op = FIFO_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dag_result_fifo.sv
// -----------------------------------------------------------------------------
// dag_result_fifo
//
// Synchronous single-clock FIFO. Storage, pointers and occupancy are all
// flops; dout/empty/full/count are decoded only from that registered state.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop from an empty FIFO is ignored.
//
// Ports:
//   clock   in   rising-edge clock
//   resetn  in   synchronous active-low reset (clears storage too)
//   push    in   request to write din at the tail
//   pop     in   request to advance the head
//   din     in   WIDTH  write data
//   dout    out  WIDTH  head entry
//   empty   out  no entries held
//   full    out  DEPTH entries held
//   count   out  log2(DEPTH)+1  current occupancy
// -----------------------------------------------------------------------------
module dag_result_fifo
  import dag_result_collector_pkg::*;
#(
  parameter  int WIDTH = DAG_RES_W,
  parameter  int DEPTH = DAG_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  // Status decoded from the registered occupancy.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests: a full FIFO still accepts a push when the head leaves.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (fifo_op(do_push, do_pop))
      FIFO_PUSH: begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
        count_d         = count_q + CNT_ONE;
      end
      FIFO_POP: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
      end
      FIFO_BOTH: begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
        rd_ptr_d        = rd_ptr_q + PTR_ONE;
      end
      FIFO_IDLE: begin
        count_d = count_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers; reset also clears storage so no stale data survives.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dag_result_collector.sv
// -----------------------------------------------------------------------------
// dag_result_collector
//
// Downstream stage of the DAG micro-benchmark datapath. A LATENCY-deep shift
// register of launch_valid marks which cycles carry a real result on the DAG
// core outputs; those results are captured into a FIFO and handed to a
// consumer over valid/ready. When the FIFO is full and not draining, a
// captured result is dropped, the sticky overflow flag is set and a
// saturating drop counter advances.
//
// Parameters:
//   BITS     width of dag_out0
//   LATENCY  launch-to-result latency of the DAG core, 1..8
//   DEPTH    FIFO entries, power of 2, >= 2
//   CNT_W    drop counter width
//
// Ports:
//   clock         in   rising-edge clock shared with the DAG core
//   resetn        in   synchronous active-low reset
//   launch_valid  in   operands launched into the DAG core this cycle are real
//   dag_out0      in   BITS  DAG core out0
//   dag_out1      in   DAG core out1
//   res_valid     out  FIFO head holds a result
//   res_ready     in   consumer accepts the head this cycle
//   res_data      out  BITS+1  head result {out1, out0}
//   res_count     out  log2(DEPTH)+1  current occupancy
//   overflow      out  sticky, a result has been dropped
//   drop_count    out  CNT_W  saturating count of dropped results
//   clear_flags   in   zero overflow and drop_count
// -----------------------------------------------------------------------------
module dag_result_collector
  import dag_result_collector_pkg::*;
#(
  parameter  int BITS    = DAG_BITS,
  parameter  int LATENCY = DAG_LATENCY,
  parameter  int DEPTH   = DAG_DEPTH,
  parameter  int CNT_W   = DAG_CNT_W,
  localparam int RES_W   = BITS + 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             launch_valid,
  input  logic [BITS-1:0]  dag_out0,
  input  logic             dag_out1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic [AW:0]      res_count,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  input  logic             clear_flags
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LATENCY-1:0] tag_q, tag_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;

  logic               cap;
  logic               pop_ok;
  logic               drop;
  logic               fifo_empty;
  logic               fifo_full;

  // The oldest tag lines up with the cycle in which the DAG outputs hold
  // the result of that launch.
  assign cap = tag_q[LATENCY-1];

  // res_valid comes from the registered occupancy, so res_ready never
  // reaches res_valid/res_data combinationally.
  assign res_valid = ~fifo_empty;
  assign pop_ok    = res_valid & res_ready;
  assign drop      = cap & fifo_full & ~pop_ok;

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

  dag_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (cap),
    .pop    (res_ready),
    .din    ({dag_out1, dag_out0}),
    .dout   (res_data),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (res_count)
  );

  // Tag pipeline: shift launch_valid along by one stage per clock.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = launch_valid;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Overflow/drop bookkeeping; a drop in the same cycle as a clear wins
  // and restarts the count at one.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_flags) begin
        drop_count_d = CNT_ONE;
      end else if (drop_count_q != CNT_MAX) begin
        drop_count_d = drop_count_q + CNT_ONE;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else if (clear_flags) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  // State registers for the tag pipeline and flags.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tag_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      tag_q        <= tag_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_dag_result_collector.sv
module tb_dag_result_collector;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int NCYC  = 2048;

  logic       clock = 1'b0;
  logic       resetn;
  logic       launch_valid;
  logic [1:0] dag_out0;
  logic       dag_out1;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_data;
  logic [2:0] res_count;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_flags;

  always #5 clock = ~clock;

  dag_result_collector #(
    .BITS    (2),
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .launch_valid (launch_valid),
    .dag_out0     (dag_out0),
    .dag_out1     (dag_out1),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_count    (res_count),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clear_flags  (clear_flags)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int max_cnt = 0;
  int n_valid = 0;

  // Stand-in for the DAG core: what was launched in each cycle.
  bit         hist_l [NCYC];
  logic [2:0] hist_d [NCYC];

  // Scoreboard / reference model state.
  logic [2:0] sb_q [$];
  bit         m_ov = 1'b0;
  int         m_dc = 0;

  typedef struct {
    bit         l;
    logic [2:0] d;
    bit         r;
    bit         exp_v;
    logic [2:0] exp_d;
    int         exp_c;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance
  // the model across the edge, then move to just after the edge.
  task automatic tick(input bit l, input logic [2:0] d, input bit r, input bit clr, input bit rst);
    bit cap;
    bit pop;
    bit drop;
    hist_l[cyc]  = l;
    hist_d[cyc]  = l ? d : 3'($urandom);
    launch_valid = l;
    res_ready    = r;
    clear_flags  = clr;
    resetn       = ~rst;
    if (cyc >= LAT) {dag_out1, dag_out0} = hist_d[cyc-LAT];
    else            {dag_out1, dag_out0} = 3'($urandom);
    #4;
    chk("res_valid", 32'(res_valid), 32'(sb_q.size() != 0));
    chk("res_count", 32'(res_count), 32'(sb_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (sb_q.size() != 0) chk("res_data", 32'(res_data), 32'(sb_q[0]));
    if (res_valid === 1'b1) n_valid++;
    if (int'(res_count) > max_cnt) max_cnt = int'(res_count);
    cap  = (cyc >= LAT) && hist_l[cyc-LAT];
    pop  = (sb_q.size() != 0) && r;
    drop = cap && (sb_q.size() == DEPTH) && !pop;
    if (rst) begin
      sb_q.delete();
      m_ov = 1'b0;
      m_dc = 0;
      for (int k = 0; k <= cyc; k++) hist_l[k] = 1'b0;
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (cap && !drop) sb_q.push_back(hist_d[cyc-LAT]);
      if (drop) begin
        m_ov = 1'b1;
        m_dc = clr ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
      end else if (clr) begin
        m_ov = 1'b0;
        m_dc = 0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    // Single-launch and two-launch vectors, rows relative to first tick.
    vt[0]  = '{1'b1, 3'b110, 1'b0, 1'b0, 3'b000, 0};
    vt[1]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 0};
    vt[2]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 0};
    vt[3]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 0};
    vt[4]  = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b110, 1};
    vt[5]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 0};
    vt[6]  = '{1'b1, 3'b011, 1'b0, 1'b0, 3'b000, 0};
    vt[7]  = '{1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 0};
    vt[8]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 0};
    vt[9]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 0};
    vt[10] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b011, 1};
    vt[11] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b011, 2};
    vt[12] = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b011, 2};
    vt[13] = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b101, 1};
    vt[14] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 0};

    resetn       = 1'b0;
    launch_valid = 1'b0;
    res_ready    = 1'b0;
    clear_flags  = 1'b0;
    dag_out0     = 2'b00;
    dag_out1     = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);

    // Table-driven single launch / pair of launches.
    for (int i = 0; i < 15; i++) begin
      chk("vec_valid", 32'(res_valid), 32'(vt[i].exp_v));
      chk("vec_count", 32'(res_count), 32'(vt[i].exp_c));
      if (vt[i].exp_v) chk("vec_data", 32'(res_data), 32'(vt[i].exp_d));
      tick(vt[i].l, vt[i].d, vt[i].r, 1'b0, 1'b0);
    end

    // Streaming: 8 back-to-back launches with the consumer always ready.
    max_cnt = 0;
    n_valid = 0;
    for (int i = 0; i < 8; i++) tick(1'b1, 3'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("stream_max_count", 32'(max_cnt), 32'd1);
    chk("stream_valid_cycles", 32'(n_valid), 32'd8);
    chk("stream_overflow", 32'(overflow), 32'd0);

    // Fill and overflow: 6 launches into a stalled consumer.
    for (int i = 0; i < 6; i++) tick(1'b1, 3'(i + 1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("fill_count", 32'(res_count), 32'd4);
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_drop_count", 32'(drop_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(res_data), 32'(i + 1));
      tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(res_valid), 32'd0);

    // Full FIFO with a capture and a pop in the same cycle.
    for (int i = 0; i < 4; i++) tick(1'b1, 3'(i + 4), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("fullpop_count", 32'(res_count), 32'd4);
    chk("fullpop_drop_count", 32'(drop_count), 32'd2);
    chk("fullpop_head", 32'(res_data), 32'd5);

    // Clear versus drop: bring drop_count to 5, then collide clear with a drop.
    for (int i = 0; i < 3; i++) tick(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_clear_drop_count", 32'(drop_count), 32'd5);
    tick(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("clear_drop_count", 32'(drop_count), 32'd1);
    chk("clear_drop_overflow", 32'(overflow), 32'd1);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("clear_alone_count", 32'(drop_count), 32'd0);
    chk("clear_alone_overflow", 32'(overflow), 32'd0);

    // Saturation of the drop counter.
    for (int i = 0; i < 258; i++) tick(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("sat_drop_count", 32'(drop_count), 32'd255);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream: 3 buffered entries and 2 tags in flight.
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("prerst_count", 32'(res_count), 32'd3);
    tick(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("postrst_valid", 32'(res_valid), 32'd0);
    chk("postrst_count", 32'(res_count), 32'd0);
    chk("postrst_overflow", 32'(overflow), 32'd0);
    chk("postrst_res_data", 32'(res_data), 32'd0);
    n_valid = 0;
    for (int i = 0; i < 8; i++) tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("postrst_no_stale", 32'(n_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dag_result_collector.md
Name: dag_result_collector

Overview:
- Downstream stage of the DAG micro-benchmark datapath.
- Tracks which launched operand sets are in flight through the fixed-latency DAG core and captures each {out1, out0} result when it emerges.
- Buffers results in a small FIFO and presents them to a consumer over a valid/ready handshake.
- Reports overflow when the consumer stalls long enough for results to be lost.

Parameters:
- BITS, 2: width of the DAG core out0 bus.
- LATENCY, 3: clock edges from operand launch to result visibility on the DAG outputs (a_in/b_in/c_in/d_in to out0/out1); legal range 1..8.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clock, in, 1: single rising-edge clock, shared with the DAG core.
- resetn, in, 1: synchronous, active-low reset.
- launch_valid, in, 1: operands presented to the DAG core this cycle are a real sample.
- dag_out0, in, BITS: DAG core out0.
- dag_out1, in, 1: DAG core out1.
- res_valid, out, 1: FIFO head holds a result.
- res_ready, in, 1: consumer accepts the head this cycle.
- res_data, out, BITS+1: head result, {out1, out0}.
- res_count, out, log2(DEPTH)+1: current occupancy.
- overflow, out, 1: sticky; set when a result was dropped.
- drop_count, out, CNT_W: number of dropped results, saturating.
- clear_flags, in, 1: clears overflow and drop_count.

Behaviour:
- Reset: resetn low at a rising edge clears everything below. Reset mid-operation discards in-flight tags and buffered results; no partial state survives.
  - Tag pipeline, read/write pointers and occupancy: 0.
  - res_valid, res_count, overflow, drop_count: 0.
  - res_data: 0.
- Tag pipeline:
  - LATENCY-stage shift register of launch_valid.
  - launch_valid high in cycle t: cap = tag[LATENCY-1] is high in cycle t+LATENCY.
  - When cap is high, dag_out0/dag_out1 are sampled at that cycle's rising edge.
  - Back-to-back launches produce back-to-back caps; there is no bubble requirement.
- Push: cap high and (not full, or pop in the same cycle) writes {dag_out1, dag_out0} at the tail.
  - A result written at edge E gives res_valid=1 in the cycle after E (one cycle capture-to-visible).
  - There is no bypass from dag_out to res_data.
- Pop: res_valid & res_ready advances the head at the edge; res_data shows the next entry in the following cycle.
  - res_ready with res_valid low has no effect.
- Simultaneous push and pop:
  - When full: both occur, count unchanged, no drop.
  - When count=1: both occur, res_valid stays high, new entry becomes the head.
- Drop: cap high, full, and no pop. The result is discarded, overflow is set, and drop_count increments, saturating at 2^CNT_W-1.
- clear_flags: zeroes overflow and drop_count at the edge. If a drop occurs in the same cycle, the drop wins over the clear: overflow=1, drop_count=1.
- Data ordering: strict FIFO in launch order; the pointer wrap at DEPTH is invisible to the consumer.
- res_data holds its value while res_valid is high and res_ready is low; it is don't-care when res_valid is low.
- All outputs are registered or decoded only from registered state; there is no combinational path from res_ready to res_valid/res_data.

Decomposition:
- Shared defines header: BITS, result width (BITS+1) and default LATENCY=3, so the DAG core, this block and benches agree on latency.
- Sub-module dag_result_fifo: synchronous FIFO, parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full, count.
  - The collector instantiates it and adds the tag pipeline, the drop/overflow logic and the clear logic.

Test Plan:
- Single launch: launch_valid pulse at cycle 0, DAG outputs out0=2'b10, out1=1 in cycle 3.
  - Required: res_valid rises in cycle 4 with res_data=3'b110; res_ready=1 in cycle 4 drops res_valid in cycle 5.
- Streaming: launch_valid held high for 8 cycles, res_ready held high.
  - Required: 8 results in launch order, res_valid continuous from cycle 4 to 11, res_count never above 1, overflow=0.
- Fill and overflow: res_ready=0, 6 consecutive launches.
  - Required: res_count reaches 4, overflow=1, drop_count=2.
  - Then res_ready=1 drains exactly results 0..3 in order.
- Full with concurrent pop: FIFO full, a cap and a pop in the same cycle.
  - Required: count stays 4, drop_count unchanged, the new result appears last.
- Clear vs drop: clear_flags in the same cycle as a drop (drop_count=5 beforehand) → drop_count=1, overflow=1.
  - Clear alone in the next cycle → both 0.
- Reset mid-stream: resetn low for 1 cycle with 2 tags in flight and 3 entries buffered.
  - Required: after reset, res_valid=0, res_count=0, overflow=0, and no stale results ever appear.
